// File: rtl/out_channel_checker.sv
// out_channel_checker
//   Consumes the words a test program emits on its output channel, buffers them
//   in a small FIFO and compares them in order against an expected-value table
//   loaded before the run. Reports completion, pass/fail and diagnostics.
//
// Ports
//   clock, reset          clock, synchronous active-high reset
//   load_valid/index/data table write, honoured only while idle
//   start                 one-cycle pulse, idle -> run
//   out_valid/out_data    producer side of the output channel
//   out_ready             checker accepts (registered)
//   finished              check complete, sticky until reset
//   success               all words matched, exact count, no timeout
//   received              words accepted so far (saturating)
//   first_bad             index of first mismatching word, 0 if none
//   timed_out             run ended because the producer went quiet
module out_channel_checker #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned IDXW       = 8,
    parameter int unsigned NEXPECT    = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [IDXW-1:0]  load_index,
    input  logic [WIDTH-1:0] load_data,
    input  logic             start,
    input  logic             out_valid,
    input  logic [WIDTH-1:0] out_data,
    output logic             out_ready,
    output logic             finished,
    output logic             success,
    output logic [IDXW:0]    received,
    output logic [IDXW-1:0]  first_bad,
    output logic             timed_out
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [IDXW:0] NEXP = (IDXW + 1)'(NEXPECT);
    localparam logic [PW:0]   FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TOUT = TW'(TIMEOUT);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;

    // Input FIFO
    logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic             fifo_empty;

    // Expected-value table, synchronous read
    logic [WIDTH-1:0] table_mem [2**IDXW];
    logic [WIDTH-1:0] ram_q;

    // Compare engine
    logic [WIDTH-1:0] hold_q;
    logic             busy_q;
    logic [IDXW:0]    cmp_idx_q;
    logic             ok_q;
    logic             surplus_q;
    logic [TW-1:0]    idle_q;

    // Registered outputs
    logic             out_ready_q, out_ready_d;
    logic             finished_q, success_q, timed_out_q;
    logic [IDXW:0]    received_q;
    logic [IDXW-1:0]  first_bad_q;

    logic xfer, surplus_now, push, pop, cmp_done, timeout_hit;

    assign fifo_empty  = (count_q == '0);
    assign xfer        = out_valid && out_ready_q;
    assign surplus_now = xfer && (received_q >= NEXP);
    // Surplus words are counted but never buffered, so they cannot block completion.
    assign push        = xfer && (state_q == StRun) && (received_q < NEXP);
    assign pop         = (state_q == StRun) && !busy_q && !fifo_empty && (cmp_idx_q < NEXP);
    assign cmp_done    = (cmp_idx_q == NEXP) && fifo_empty && !busy_q;
    assign timeout_hit = (idle_q == TOUT) && !xfer && (cmp_idx_q < NEXP);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PW + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (PW + 1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (cmp_done || timeout_hit) state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Ready follows the registered occupancy only; DONE always accepts so a
    // runaway producer never stalls.
    always_comb begin
        out_ready_d = 1'b0;
        if (state_d == StDone) begin
            out_ready_d = 1'b1;
        end else if (state_d == StRun) begin
            out_ready_d = (count_d != FULL);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            cmp_idx_q   <= '0;
            ok_q        <= 1'b1;
            surplus_q   <= 1'b0;
            idle_q      <= '0;
            out_ready_q <= 1'b0;
            finished_q  <= 1'b0;
            success_q   <= 1'b0;
            timed_out_q <= 1'b0;
            received_q  <= '0;
            first_bad_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_ready_q <= out_ready_d;

            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                busy_q   <= 1'b1;
            end

            // CMP cycle: ram_q now holds table[cmp_idx_q] read on the pop edge.
            if (busy_q) begin
                if (ok_q && (hold_q != ram_q)) begin
                    first_bad_q <= cmp_idx_q[IDXW-1:0];
                    ok_q        <= 1'b0;
                end
                cmp_idx_q <= cmp_idx_q + (IDXW + 1)'(1);
                busy_q    <= 1'b0;
            end

            if (xfer && (received_q != '1)) received_q <= received_q + (IDXW + 1)'(1);
            if (surplus_now) surplus_q <= 1'b1;

            if (state_q == StRun) begin
                if (xfer) begin
                    idle_q <= '0;
                end else if (idle_q != TOUT) begin
                    idle_q <= idle_q + TW'(1);
                end
            end else begin
                idle_q <= '0;
            end

            if ((state_q == StRun) && (state_d == StDone)) begin
                finished_q <= 1'b1;
                if (timeout_hit) begin
                    timed_out_q <= 1'b1;
                    success_q   <= 1'b0;
                end else begin
                    success_q <= ok_q && !surplus_q && !surplus_now;
                end
            end

            if ((state_q == StDone) && surplus_now) success_q <= 1'b0;
        end
    end

    // Storage without reset: FIFO slots, holding register, table RAM.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= out_data;
        if (pop) hold_q <= fifo_mem[rd_ptr_q];
        if (load_valid && (state_q == StIdle)) table_mem[load_index] <= load_data;
        ram_q <= table_mem[cmp_idx_q[IDXW-1:0]];
    end

    assign out_ready = out_ready_q;
    assign finished  = finished_q;
    assign success   = success_q;
    assign received  = received_q;
    assign first_bad = first_bad_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_out_channel_checker.sv
// Self-checking bench for out_channel_checker. Four instances with NEXPECT of
// 1, 2, 3 and 8 share the stimulus bus; sel routes load/start/valid to one.
module tb_out_channel_checker;

    localparam int W   = 12;
    localparam int IW  = 8;
    localparam int TMO = 64;

    logic          clock = 1'b0;
    logic          reset, load_valid, start, out_valid;
    logic [IW-1:0] load_index;
    logic [W-1:0]  load_data, out_data;
    logic [1:0]    sel;

    logic          rdy_a  [4];
    logic          fin_a  [4];
    logic          succ_a [4];
    logic          to_a   [4];
    logic [IW:0]   recv_a [4];
    logic [IW-1:0] fb_a   [4];

    int total = 0;
    int bad   = 0;

    logic [W-1:0] tab_m [4][256];
    logic [W-1:0] sent_q [$];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned NE = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 8;
        out_channel_checker #(
            .WIDTH(W), .IDXW(IW), .NEXPECT(NE), .FIFO_DEPTH(4), .TIMEOUT(TMO)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .load_valid(load_valid && (sel == 2'(g))),
            .load_index(load_index),
            .load_data (load_data),
            .start     (start && (sel == 2'(g))),
            .out_valid (out_valid && (sel == 2'(g))),
            .out_data  (out_data),
            .out_ready (rdy_a[g]),
            .finished  (fin_a[g]),
            .success   (succ_a[g]),
            .received  (recv_a[g]),
            .first_bad (fb_a[g]),
            .timed_out (to_a[g])
        );
    end

    function automatic int ne_of(input logic [1:0] k);
        case (k)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 3;
            default: return 8;
        endcase
    endfunction

    // Expected {finished, success, received, first_bad, timed_out} from the words sent.
    function automatic logic [19:0] model_tuple(input logic [1:0] k);
        int          ne = ne_of(k);
        int          n  = sent_q.size();
        logic        ok = 1'b1;
        logic [7:0]  fb = '0;
        logic        to;
        for (int i = 0; i < n && i < ne; i++) begin
            if (ok && (sent_q[i] !== tab_m[k][i])) begin
                ok = 1'b0;
                fb = 8'(i);
            end
        end
        to = (n < ne);
        return {1'b1, ok && (n == ne) && !to, 9'(n), fb, to};
    endfunction

    function automatic logic [19:0] obs_tuple(input logic [1:0] k);
        return {fin_a[k], succ_a[k], recv_a[k], fb_a[k], to_a[k]};
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; out_valid = 1'b0; start = 1'b0; load_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        sent_q.delete();
    endtask

    task automatic load_word(input logic [1:0] k, input int idx, input logic [W-1:0] v);
        tab_m[k][idx] = v;
        sel = k; load_valid = 1'b1; load_index = 8'(idx); load_data = v;
        @(negedge clock);
        load_valid = 1'b0;
    endtask

    task automatic load_random(input logic [1:0] k);
        for (int i = 0; i < ne_of(k); i++) load_word(k, i, W'($urandom_range(0, 4095)));
    endtask

    task automatic pulse_start(input logic [1:0] k);
        sel = k; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Single handshake; called and returns at a negedge.
    task automatic send_word(input logic [W-1:0] d);
        int guard = 0;
        out_valid = 1'b1; out_data = d;
        while (!rdy_a[sel] && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (!rdy_a[sel]) begin
            total++; bad++;
            $display("FAIL handshake: out_ready stuck at 0 for 200 cycles, required 1");
            out_valid = 1'b0;
            return;
        end
        @(posedge clock);
        sent_q.push_back(d);
        @(negedge clock);
        out_valid = 1'b0;
    endtask

    task automatic wait_fin(input int budget, output int cycles);
        cycles = 0;
        while (!fin_a[sel] && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({rdy_a[k], obs_tuple(2'(k))} !== 21'b0) begin
                bad++;
                $display("FAIL reset[%0d]: got=%h required=0", k, {rdy_a[k], obs_tuple(2'(k))});
            end
        end
    endtask

    task automatic test_single();
        int cyc;
        do_reset();
        load_word(2'd0, 0, 12'd2);
        pulse_start(2'd0);
        send_word(12'd2);
        wait_fin(4, cyc);
        total++;
        if (fin_a[0] !== 1'b1) begin
            bad++;
            $display("FAIL single.latency: finished=%b after %0d cycles, required 1 within 4",
                     fin_a[0], cyc);
        end
        total++;
        if (obs_tuple(2'd0) !== model_tuple(2'd0)) begin
            bad++;
            $display("FAIL single.result: got=%h required=%h", obs_tuple(2'd0), model_tuple(2'd0));
        end
    endtask

    // Continues the finished single-word run with one surplus word.
    task automatic test_surplus();
        total++;
        if (rdy_a[0] !== 1'b1) begin
            bad++;
            $display("FAIL surplus.ready_done: got=%b required=1", rdy_a[0]);
        end
        send_word(12'd3);
        repeat (3) @(negedge clock);
        total++;
        if (obs_tuple(2'd0) !== model_tuple(2'd0)) begin
            bad++;
            $display("FAIL surplus.result: got=%h required=%h", obs_tuple(2'd0), model_tuple(2'd0));
        end
    endtask

    task automatic test_mismatch();
        int cyc;
        for (int r = 0; r < 3; r++) begin
            int b;
            do_reset();
            load_random(2'd2);
            b = $urandom_range(0, 3);
            pulse_start(2'd2);
            for (int i = 0; i < 3; i++) begin
                logic [W-1:0] d;
                d = tab_m[2][i];
                if (i == b) d = d ^ W'($urandom_range(1, 4095));
                send_word(d);
            end
            wait_fin(20, cyc);
            total++;
            if (obs_tuple(2'd2) !== model_tuple(2'd2)) begin
                bad++;
                $display("FAIL mismatch[%0d]: got=%h required=%h", r, obs_tuple(2'd2),
                         model_tuple(2'd2));
            end
        end
    endtask

    task automatic test_back_to_back();
        int i = 0, guard = 0, stall_at = -1, cyc;
        do_reset();
        for (int j = 0; j < 8; j++) load_word(2'd3, j, W'(j + 1));
        pulse_start(2'd3);
        out_valid = 1'b1; out_data = tab_m[3][0];
        while (i < 8 && guard < 100) begin
            if (rdy_a[3]) begin
                @(posedge clock);
                sent_q.push_back(out_data);
                i++;
                @(negedge clock);
                if (i < 8) out_data = tab_m[3][i];
            end else begin
                if (stall_at < 0) stall_at = i;
                @(negedge clock);
            end
            guard++;
        end
        out_valid = 1'b0;
        total++;
        if (i != 8) begin
            bad++;
            $display("FAIL b2b.accepted: got=%0d required=8", i);
        end
        total++;
        if (stall_at < 4 || stall_at > 7) begin
            bad++;
            $display("FAIL b2b.backpressure: first stall after %0d words, required 4..7", stall_at);
        end
        wait_fin(20, cyc);
        total++;
        if (obs_tuple(2'd3) !== model_tuple(2'd3)) begin
            bad++;
            $display("FAIL b2b.result: got=%h required=%h", obs_tuple(2'd3), model_tuple(2'd3));
        end
    endtask

    task automatic test_timeout();
        int cyc;
        do_reset();
        load_random(2'd1);
        pulse_start(2'd1);
        send_word(tab_m[1][0]);
        repeat (40) @(negedge clock);
        total++;
        if (fin_a[1] !== 1'b0) begin
            bad++;
            $display("FAIL timeout.early: finished=%b after 40 idle cycles, required 0", fin_a[1]);
        end
        wait_fin(60, cyc);
        total++;
        if (obs_tuple(2'd1) !== model_tuple(2'd1)) begin
            bad++;
            $display("FAIL timeout.result: got=%h required=%h", obs_tuple(2'd1), model_tuple(2'd1));
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        do_reset();
        load_random(2'd3);
        pulse_start(2'd3);
        send_word(tab_m[3][0]);
        send_word(tab_m[3][1]);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if ({rdy_a[3], obs_tuple(2'd3)} !== 21'b0) begin
            bad++;
            $display("FAIL midrun.reset: got=%h required=0", {rdy_a[3], obs_tuple(2'd3)});
        end
        sent_q.delete();
        pulse_start(2'd3);
        for (int i = 0; i < 8; i++) send_word(tab_m[3][i]);
        wait_fin(20, cyc);
        total++;
        if (obs_tuple(2'd3) !== model_tuple(2'd3)) begin
            bad++;
            $display("FAIL midrun.rerun: got=%h required=%h", obs_tuple(2'd3), model_tuple(2'd3));
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int r = 0; r < 4; r++) begin
            int n;
            do_reset();
            if (r[0]) load_random(2'd3);
            n = 8 + int'($urandom_range(0, 1));
            pulse_start(2'd3);
            for (int i = 0; i < n; i++) begin
                logic [W-1:0] d;
                d = (i < 8) ? tab_m[3][i] : W'($urandom_range(0, 4095));
                if ($urandom_range(0, 7) == 0) d = d ^ W'($urandom_range(1, 4095));
                send_word(d);
                repeat ($urandom_range(0, 3)) @(negedge clock);
            end
            wait_fin(40, cyc);
            repeat (2) @(negedge clock);
            total++;
            if (obs_tuple(2'd3) !== model_tuple(2'd3)) begin
                bad++;
                $display("FAIL random[%0d]: got=%h required=%h", r, obs_tuple(2'd3),
                         model_tuple(2'd3));
            end
        end
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; start = 1'b0; out_valid = 1'b0;
        load_index = '0; load_data = '0; out_data = '0; sel = '0;
        test_reset();
        test_single();
        test_surplus();
        test_mismatch();
        test_back_to_back();
        test_timeout();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
